// File: rtl/ctr_sched.sv
// ctr_sched: round-robin scheduler sharing one counter between NREQ requesters.
// Each granted job programs the counter stop value, clears the counter for one
// cycle, releases it and waits for done (or a timeout). It then reports the
// elapsed RUN cycles tagged with the requester id.
//
// state | meaning
// IDLE  | arbitrate over req_valid, grant one requester
// CLEAR | counter held cleared with the new stop value applied
// RUN   | counter released, run count k advances until done or timeout
// RESP  | completion presented until resp_ready
`timescale 1ns/1ps
module ctr_sched #(
  parameter int NREQ       = 4,
  parameter int STOP_WIDTH = 1,
  parameter int CYC_WIDTH  = 16,
  parameter int TIMEOUT    = 1000,
  parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*STOP_WIDTH-1:0] req_stop,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [IDW-1:0]             resp_id,
  output logic [CYC_WIDTH-1:0]       resp_cycles,
  output logic                       resp_err,
  output logic                       cnt_clr_l,
  output logic [STOP_WIDTH-1:0]      cnt_stop,
  input  logic                       cnt_done,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  localparam logic [CYC_WIDTH-1:0] TIMEOUT_C = CYC_WIDTH'(TIMEOUT);
  localparam logic [IDW:0]         NREQ_C    = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]       LAST_ID   = IDW'(NREQ - 1);

  state_t                state;
  state_t                state_nxt;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        grant_id;
  logic                  grant_found;
  logic                  accept;
  logic [IDW:0]          arb_sum;
  logic [IDW-1:0]        arb_idx;
  logic [CYC_WIDTH-1:0]  run_k;
  logic                  run_timeout;
  logic [STOP_WIDTH-1:0] stop_arr [NREQ];

  // Unpack the flat stop bus into one slice per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stop
    assign stop_arr[gi] = req_stop[gi*STOP_WIDTH +: STOP_WIDTH];
  end

  assign accept      = |(req_valid & req_ready);
  assign run_timeout = (run_k == TIMEOUT_C);

  // Round-robin search: first valid requester starting from rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    arb_sum     = '0;
    arb_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (arb_sum >= NREQ_C) arb_sum = arb_sum - NREQ_C;
      arb_idx = arb_sum[IDW-1:0];
      if (!grant_found && req_valid[arb_idx]) begin
        grant_found = 1'b1;
        grant_id    = arb_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; done wins over timeout in the same RUN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (cnt_done || run_timeout) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: grant only in IDLE, completion only in RESP.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_id] = 1'b1;
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  // Job datapath: latch the grant, drive the counter, time the run.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rr_ptr      <= '0;
      cnt_clr_l   <= 1'b0;
      cnt_stop    <= '0;
      resp_id     <= '0;
      resp_cycles <= '0;
      resp_err    <= 1'b0;
      run_k       <= '0;
    end else begin
      // Registered so the counter sees its release exactly on the first RUN cycle.
      cnt_clr_l <= (state_nxt == RUN);
      if (accept) begin
        cnt_stop <= stop_arr[grant_id];
        resp_id  <= grant_id;
        rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
      case (state)
        CLEAR: run_k <= '0;
        RUN: begin
          if (cnt_done) begin
            resp_cycles <= run_k;
            resp_err    <= 1'b0;
          end else if (run_timeout) begin
            resp_cycles <= TIMEOUT_C;
            resp_err    <= 1'b1;
          end else begin
            run_k <= run_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ctr_sched.md
Name: ctr_sched

Overview:
Round-robin scheduler that shares one Counter instance between NREQ requesters.
- Each requester submits a stop value.
- The scheduler programs the counter, clears it, releases it and waits for done.
- It then returns the elapsed cycle count, tagged with the requester id.
- It sits between the testbench/SST-facing request ports and the counter model.

Parameters:
NREQ, 4, number of requesters (≥1)
STOP_WIDTH, 1, width of stop value; equals the counter's STOP_WIDTH
CYC_WIDTH, 16, width of resp_cycles and of the internal run counter
TIMEOUT, 1000, maximum RUN cycles before abort; must be < 2^CYC_WIDTH
IDW, max(1,$clog2(NREQ)), width of the requester id

Ports:
clk  in  1  clock
reset_l  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept (one-hot or zero)
req_stop  in  NREQ*STOP_WIDTH  stop values; slice i belongs to requester i
resp_valid  out  1  completion valid
resp_ready  in  1  completion accept
resp_id  out  IDW  requester id of the completed job
resp_cycles  out  CYC_WIDTH  RUN cycles until done (TIMEOUT on abort)
resp_err  out  1  1 = job aborted by timeout
cnt_clr_l  out  1  drives the counter's reset_l; registered
cnt_stop  out  STOP_WIDTH  drives the counter's stop; registered
cnt_done  in  1  the counter's done
busy  out  1  state != IDLE

Behaviour:
- Reset values (async, reset_l low):
  - State = IDLE; RR pointer = 0.
  - cnt_clr_l=0, cnt_stop=0, resp_valid=0, resp_id=0, resp_cycles=0, resp_err=0, req_ready=0.
  - Any in-flight job is dropped silently.
- States: IDLE -> CLEAR -> RUN -> RESP -> IDLE.
- IDLE:
  - Round-robin arbiter over req_valid; search starts at (last_grant+1) mod NREQ, pointer 0 after reset.
  - req_ready[g] = 1 combinationally for the winner only, and only in IDLE.
  - Accept = req_valid[g] & req_ready[g].
  - On accept: latch id=g and stop=req_stop[g]; go to CLEAR; last_grant=g.
  - Requesters hold valid and stop stable until accepted.
- CLEAR (1 cycle):
  - cnt_stop = latched stop; cnt_clr_l = 0.
  - Run counter k = 0; next state RUN.
- RUN:
  - cnt_clr_l = 1 from the first RUN cycle; the counter shows ctr = k in RUN cycle k.
  - Each cycle: if cnt_done, set resp_cycles = k, resp_err = 0, go to RESP.
  - Else if k == TIMEOUT, set resp_cycles = TIMEOUT, resp_err = 1, go to RESP.
  - Else k = k+1.
  - Done takes priority over timeout in the same cycle.
- RESP:
  - resp_valid = 1; resp_id, resp_cycles and resp_err stay stable until resp_ready.
  - cnt_clr_l = 0 (counter held cleared); no grants.
  - On handshake, go to IDLE. Earliest new grant is the following cycle.
- Latency: accept at cycle T gives resp_valid at T+3+stop when cnt_done is correct.
- Job throughput: minimum stop+4 cycles per job.
- cnt_clr_l is 0 in every state except RUN.
- cnt_stop holds its value from CLEAR through RESP and keeps its last value in IDLE.
- Stop = 0: done is seen in RUN cycle 0, so resp_cycles = 0.
- A stop value > TIMEOUT yields a timeout error.
- Counter wrap-around is not observable: the counter resets each job, and the job ends at done.
- Widths: resp_cycles is zero-extended to CYC_WIDTH; k saturates logic-wise at TIMEOUT and never wraps.
- Reset mid-operation: all outputs return to reset values immediately (async); the counter is cleared via cnt_clr_l=0.

Test Plan:
1. Single job: req_valid[0], stop=5 accepted at T (STOP_WIDTH=4) -> cnt_clr_l=1 at T+2..T+7, resp_valid at T+8, resp_id=0, resp_cycles=5, resp_err=0.
2. Stop=0 on requester 2 -> resp_cycles=0, resp_valid 3 cycles after accept, resp_id=2.
3. All 4 requesters hold req_valid with stops 1,2,3,4; resp_ready=1 -> grant order 0,1,2,3,0; each resp_cycles equals that requester's stop; req_ready is never multi-hot.
4. cnt_done forced low, TIMEOUT=20 -> resp_err=1, resp_cycles=20, resp_valid 23 cycles after accept.
5. resp_ready low for 10 cycles in RESP -> resp_* stable, req_ready=0, cnt_clr_l=0, busy=1; completion is consumed on the first resp_ready=1 cycle.
6. reset_l pulsed low in RUN (stop=7, k=3) -> outputs reset immediately, busy=0. A new request after reset is granted to requester 0 first and completes with resp_cycles=7.
